// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: size encodings,
// FSM state and completion-kind enums, default bus timeout, and the helpers
// that build byte enables and lane-replicated store data.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_X = 2'd3;  // illegal size, aborts with err

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // Which completion pulse DONE will emit.
  typedef enum logic [1:0] {
    CMP_LOAD  = 2'd0,
    CMP_STORE = 2'd1,
    CMP_ERR   = 2'd2,
    CMP_MIS   = 2'd3
  } lsu_cmp_e;

  // Byte enables for an (already aligned) access.
  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << addr_lo;
      SIZE_H:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data into every lane it may occupy.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SIZE_B:  lanes = {4{wdata[7:0]}};
      SIZE_H:  lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: selects the addressed byte/half lane of a read word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane select by low address bits, then extension by size/signedness.
  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_B:  data = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SIZE_H:  data = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit. Takes one load or store per
// transaction, runs a req/ack bus transfer with a timeout, and returns
// aligned, extended load data.
//
// Handshake: the pipeline's operation is taken on a rising edge where
// req_valid & req_ready (req_ready is high only in IDLE); req_valid in any
// other state is ignored. On the bus, bus_req stays high with stable
// address/enables/data until a cycle with bus_ack (transfer complete) or
// until the timeout aborts it; bus_ack outside BUS is ignored.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, misaligned
// half/word accesses skip the bus and pulse misalign; when undefined they are
// forced aligned and misalign is tied low.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT  // legal range 1..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        store_done,
  output logic        err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  lsu_state_e  state_q, state_d;
  lsu_cmp_e    cmp_q, cmp_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;

  logic [31:0] eff_addr;
  logic        trap;
  logic [8:0]  cnt_inc;
  logic [31:0] align_data;

  load_align u_load_align (
    .rdata       (bus_rdata),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (align_data)
  );

  // Decode misalignment of the incoming request: trap it or force it aligned.
  always_comb begin
    eff_addr = req_addr;
    trap     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = ((req_size == SIZE_H) && req_addr[0]) ||
           ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
`else
    if (req_size == SIZE_H) eff_addr[0]   = 1'b0;
    if (req_size == SIZE_W) eff_addr[1:0] = 2'b00;
`endif
  end

  // Next-state logic: capture in IDLE, bus transfer with timeout, one DONE cycle.
  always_comb begin
    state_d     = state_q;
    cmp_d       = cmp_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    cnt_inc     = {1'b0, cnt_q} + 9'd1;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = eff_addr;
          be_d    = byte_enables(req_size, eff_addr[1:0]);
          wdata_d = store_lanes(req_size, req_wdata);
          cnt_d   = 8'd0;
          if (req_size == SIZE_X) begin
            state_d     = ST_DONE;
            cmp_d       = CMP_ERR;
            load_data_d = 32'd0;
          end else if (trap) begin
            state_d     = ST_DONE;
            cmp_d       = CMP_MIS;
            load_data_d = 32'd0;
          end else begin
            state_d = ST_BUS;
            cmp_d   = req_write ? CMP_STORE : CMP_LOAD;
          end
        end
      end
      ST_BUS: begin
        cnt_d = cnt_inc[7:0];
        // An ack in the timeout cycle still completes normally.
        if (bus_ack) begin
          state_d = ST_DONE;
          if (!write_q) load_data_d = align_data;
        end else if (cnt_inc == 9'(TIMEOUT)) begin
          state_d     = ST_DONE;
          cmp_d       = CMP_ERR;
          load_data_d = 32'd0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmp_q       <= CMP_LOAD;
      cnt_q       <= 8'd0;
      write_q     <= 1'b0;
      size_q      <= SIZE_B;
      uns_q       <= 1'b0;
      addr_q      <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cmp_q       <= cmp_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign stall      = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_BUS);
  assign bus_req    = (state_q == ST_BUS);
  assign bus_we     = bus_req & write_q;
  assign bus_addr   = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_be     = bus_req ? be_q : 4'd0;
  assign bus_wdata  = bus_req ? wdata_q : 32'd0;
  assign load_data  = load_data_q;
  assign load_valid = (state_q == ST_DONE) && (cmp_q == CMP_LOAD);
  assign store_done = (state_q == ST_DONE) && (cmp_q == CMP_STORE);
  assign err        = (state_q == ST_DONE) && (cmp_q == CMP_ERR);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign   = (state_q == ST_DONE) && (cmp_q == CMP_MIS);
`else
  assign misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit. Inputs are driven 1 time unit after
// each rising edge; outputs are sampled 3 units after the edge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, stall, load_valid, store_done, err, misalign;
  logic [31:0] load_data;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .stall        (stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .store_done   (store_done),
    .err          (err),
    .misalign     (misalign),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Present a request for one cycle; returns at the first cycle after accept.
  task automatic accept(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    settle();
    chk("accept_ready", {31'd0, req_ready}, 32'd1);
    chk("accept_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    req_valid = 1'b0;
  endtask

  // Load acked in its first bus cycle.
  task automatic load_quick(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
    exp_q.push_back(exp_data);
    accept(1'b0, sz, uns, addr, 32'd0);
    bus_ack = 1'b1; bus_rdata = rdata;
    settle();
    chk({tag, "_bus_req"}, {31'd0, bus_req}, 32'd1);
    chk({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, exp_addr);
    chk({tag, "_bus_be"}, {28'd0, bus_be}, {28'd0, exp_be});
    chk({tag, "_lv_early"}, {31'd0, load_valid}, 32'd0);
    next_cycle();
    bus_ack = 1'b0; bus_rdata = 32'd0;
    settle();
    chk({tag, "_load_valid"}, {31'd0, load_valid}, 32'd1);
    chk({tag, "_load_data"}, load_data, exp_q.pop_front());
    chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    next_cycle();
    settle();
    chk({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_lv_after"}, {31'd0, load_valid}, 32'd0);
    chk({tag, "_held"}, load_data, exp_data);
    next_cycle();
  endtask

  initial begin
    int stall_cnt, done_cnt, req_cnt, err_cnt;

    // Reset
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_pulses", {28'd0, load_valid, store_done, err, misalign}, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    reset = 1'b0;
    next_cycle();

    // Loads with immediate ack across sizes and extension modes
    load_quick("lb_s_1003", 2'd0, 1'b0, 32'h0000_1003, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);
    load_quick("lh_u_5002", 2'd1, 1'b1, 32'h0000_5002, 32'h8001_7FFF, 32'h0000_5000, 4'b1100, 32'h0000_8001);
    load_quick("lh_s_5002", 2'd1, 1'b0, 32'h0000_5002, 32'h8001_7FFF, 32'h0000_5000, 4'b1100, 32'hFFFF_8001);
    load_quick("lh_s_5000", 2'd1, 1'b0, 32'h0000_5000, 32'h8001_7FFF, 32'h0000_5000, 4'b0011, 32'h0000_7FFF);
    load_quick("lb_u_5001", 2'd0, 1'b1, 32'h0000_5001, 32'h0000_9A00, 32'h0000_5000, 4'b0010, 32'h0000_009A);

    // Store half 0xABCD at 0x2002, ack in the third bus cycle
    stall_cnt = 1; done_cnt = 0;
    accept(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_ABCD);
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) bus_ack = 1'b1;
      settle();
      if (stall) stall_cnt++;
      chk("sh_bus_req", {31'd0, bus_req}, 32'd1);
      chk("sh_bus_we", {31'd0, bus_we}, 32'd1);
      chk("sh_bus_be", {28'd0, bus_be}, 32'h0000_000C);
      chk("sh_bus_wdata", bus_wdata, 32'hABCD_ABCD);
      chk("sh_bus_addr", bus_addr, 32'h0000_2000);
      next_cycle();
      bus_ack = 1'b0;
    end
    settle();
    if (stall) stall_cnt++;
    if (store_done) done_cnt++;
    chk("sh_done_bus_req", {31'd0, bus_req}, 32'd0);
    chk("sh_done_lv", {31'd0, load_valid}, 32'd0);
    next_cycle();
    settle();
    if (store_done) done_cnt++;
    chk("sh_ready_after", {31'd0, req_ready}, 32'd1);
    chk("sh_stall_cycles", stall_cnt, 32'd4);
    chk("sh_store_done_count", done_cnt, 32'd1);
    chk("sh_load_data_held", load_data, 32'h0000_009A);
    next_cycle();

    // Byte store at 0x6001
    accept(1'b1, 2'd0, 1'b0, 32'h0000_6001, 32'h1234_565A);
    bus_ack = 1'b1;
    settle();
    chk("sb_bus_be", {28'd0, bus_be}, 32'h0000_0002);
    chk("sb_bus_wdata", bus_wdata, 32'h5A5A_5A5A);
    next_cycle();
    bus_ack = 1'b0;
    settle();
    chk("sb_store_done", {31'd0, store_done}, 32'd1);
    next_cycle();
    next_cycle();

    // Word load never acked: timeout after 16 bus cycles
    req_cnt = 0; err_cnt = 0;
    bus_rdata = 32'hDEAD_BEEF;
    accept(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      settle();
      if (bus_req) req_cnt++;
      if (err) err_cnt++;
      next_cycle();
    end
    settle();
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_lv", {31'd0, load_valid}, 32'd0);
    chk("to_load_data", load_data, 32'd0);
    chk("to_bus_req_drop", {31'd0, bus_req}, 32'd0);
    chk("to_bus_cycles", req_cnt, 32'd16);
    chk("to_err_early", err_cnt, 32'd0);
    next_cycle();
    settle();
    chk("to_err_single", {31'd0, err}, 32'd0);
    chk("to_ready_after", {31'd0, req_ready}, 32'd1);
    next_cycle();

    // Ack in the 16th bus cycle wins over the timeout
    err_cnt = 0;
    exp_q.push_back(32'h1234_5678);
    accept(1'b0, 2'd2, 1'b0, 32'h0000_4004, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      end
      settle();
      if (err) err_cnt++;
      next_cycle();
      bus_ack = 1'b0;
    end
    settle();
    chk("ack16_err", {31'd0, err}, 32'd0);
    chk("ack16_err_early", err_cnt, 32'd0);
    chk("ack16_lv", {31'd0, load_valid}, 32'd1);
    chk("ack16_load_data", load_data, exp_q.pop_front());
    next_cycle();
    settle();
    chk("ack16_ready_after", {31'd0, req_ready}, 32'd1);
    next_cycle();

    // Misaligned word load at 0x3002
`ifdef LSU_MISALIGN_TRAP_EN
    req_cnt = 0;
    accept(1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'd0);
    settle();
    if (bus_req) req_cnt++;
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_lv", {31'd0, load_valid}, 32'd0);
    chk("mis_load_data", load_data, 32'd0);
    next_cycle();
    settle();
    if (bus_req) req_cnt++;
    chk("mis_single", {31'd0, misalign}, 32'd0);
    chk("mis_ready_after", {31'd0, req_ready}, 32'd1);
    chk("mis_no_bus", req_cnt, 32'd0);
    next_cycle();
`else
    load_quick("lw_mis_3002", 2'd2, 1'b0, 32'h0000_3002, 32'hCAFE_F00D, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D);
    load_quick("lh_mis_3001", 2'd1, 1'b0, 32'h0000_3001, 32'h1234_ABCD, 32'h0000_3000, 4'b0011, 32'hFFFF_ABCD);
`endif

    // Illegal size: err one cycle after accept, no bus activity
    req_cnt = 0;
    accept(1'b0, 2'd3, 1'b0, 32'h0000_7000, 32'd0);
    settle();
    if (bus_req) req_cnt++;
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_lv", {31'd0, load_valid}, 32'd0);
    chk("ill_load_data", load_data, 32'd0);
    next_cycle();
    settle();
    if (bus_req) req_cnt++;
    chk("ill_no_bus", req_cnt, 32'd0);
    chk("ill_ready_after", {31'd0, req_ready}, 32'd1);
    next_cycle();

    // Reset during BUS with an ack pending
    load_quick("lw_pre_rst", 2'd2, 1'b1, 32'h0000_8800, 32'h0BAD_F00D, 32'h0000_8800, 4'b1111, 32'h0BAD_F00D);
    accept(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'd0);
    settle();
    chk("rstmid_bus_req_before", {31'd0, bus_req}, 32'd1);
    reset = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    #1;
    chk("rstmid_bus_req_async", {31'd0, bus_req}, 32'd0);
    chk("rstmid_ready_async", {31'd0, req_ready}, 32'd1);
    next_cycle();
    reset = 1'b0;
    settle();
    chk("rstmid_no_pulse0", {28'd0, load_valid, store_done, err, misalign}, 32'd0);
    chk("rstmid_ready0", {31'd0, req_ready}, 32'd1);
    chk("rstmid_load_data", load_data, 32'd0);
    next_cycle();
    bus_ack = 1'b0; bus_rdata = 32'd0;
    settle();
    chk("rstmid_no_pulse1", {28'd0, load_valid, store_done, err, misalign}, 32'd0);
    chk("rstmid_bus_idle", {31'd0, bus_req}, 32'd0);
    chk("rstmid_ready1", {31'd0, req_ready}, 32'd1);
    next_cycle();

    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
